// File: rtl/counter_debouncer_clkdiv_top.sv
// Single-digit counter demo: clock-enable divider, switch sync/debounce, 4-bit up/down counter, 7-seg decode.
// Latency: switch edge to debounced change is 2 + DEBOUNCE_COUNT cycles; count moves on the cycle after a tick.
// Backpressure: none; free-running with no handshakes, display_1 decodes the count combinationally.
module counter_debouncer_clkdiv_top #(
    parameter int DIV_COUNT      = 50_000_000,
    parameter int DEBOUNCE_COUNT = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] data_in,
    output logic [6:0] display_1
);

    localparam int DIVW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int DBW  = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV_COUNT - 1);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_COUNT - 1);

    typedef struct packed {
        logic       up_down;
        logic       load;
        logic [3:0] data;
    } sw_t;

    sw_t             sw_meta;
    sw_t             sw_sync;
    logic [DIVW-1:0] div_cnt;
    logic            tick;
    logic [1:0]      db_in;
    logic [1:0]      db_q;
    logic [DBW-1:0]  db_cnt [2];
    logic            up_down_db;
    logic            load_db;
    logic [3:0]      count;

    // Raw switches are asynchronous to clk; two flops before any use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= '{up_down: up_down, load: load, data: data_in};
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIVW'(1);
            end
        end
    end

    assign db_in = {sw_sync.load, sw_sync.up_down};

    // The stable counter only runs while a change is pending; any return to the old level restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (db_in[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_q[i]   <= db_in[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign up_down_db = db_q[0];
    assign load_db    = db_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'h0;
        end else if (load_db) begin
            count <= sw_sync.data;
        end else if (tick) begin
            count <= up_down_db ? count + 4'h1 : count - 4'h1;
        end
    end

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    always_comb begin
        display_1 = 7'b1000000;
        case (count)
            4'h0: display_1 = 7'b1000000;
            4'h1: display_1 = 7'b1111001;
            4'h2: display_1 = 7'b0100100;
            4'h3: display_1 = 7'b0110000;
            4'h4: display_1 = 7'b0011001;
            4'h5: display_1 = 7'b0010010;
            4'h6: display_1 = 7'b0000010;
            4'h7: display_1 = 7'b1111000;
            4'h8: display_1 = 7'b0000000;
            4'h9: display_1 = 7'b0010000;
            4'hA: display_1 = 7'b0001000;
            4'hB: display_1 = 7'b0000011;
            4'hC: display_1 = 7'b1000110;
            4'hD: display_1 = 7'b0100001;
            4'hE: display_1 = 7'b0000110;
            4'hF: display_1 = 7'b0001110;
            default: display_1 = 7'b1000000;
        endcase
    end

endmodule

// File: tb/tb_counter_debouncer_clkdiv_top.sv
// Directed bench for the counter demo top: down/up wrap, debounce timing, load priority, async reset.
// Inputs change and outputs are sampled 2 time units after a rising edge; clock period is 10.
module tb_counter_debouncer_clkdiv_top;

    logic       clk;
    logic       rst;
    logic       up_down;
    logic       load;
    logic [3:0] data_in;
    logic [6:0] display_1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t sb [$];

    counter_debouncer_clkdiv_top #(
        .DIV_COUNT      (2),
        .DEBOUNCE_COUNT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_down   (up_down),
        .load      (load),
        .data_in   (data_in),
        .display_1 (display_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    task automatic push(input string tag, input logic [3:0] digit);
        exp_t e;
        e.tag = tag;
        e.exp = seg(digit);
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: no expectation queued, display_1=%b", display_1);
        end else begin
            e = sb.pop_front();
            assert (display_1 === e.exp) else begin
                n_fail++;
                $error("FAIL %s: display_1=%b required %b", e.tag, display_1, e.exp);
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Edge numbers En count rising edges after reset release; count updates on odd edges from E3.
    initial begin
        rst     = 1'b0;
        up_down = 1'b0;
        load    = 1'b0;
        data_in = 4'bxxxx;
        repeat (2) @(posedge clk);
        #2;
        push("rst_held", 4'h0);     pop_check();
        rst = 1'b1;
        push("after_release", 4'h0); pop_check();
        push("before_tick", 4'h0);  adv(2);  pop_check();   // E2
        push("down_wrap_f", 4'hF);  adv(1);  pop_check();   // E3
        push("down_e", 4'hE);       adv(2);  pop_check();   // E5
        push("down_d", 4'hD);       adv(2);  pop_check();   // E7

        up_down = 1'b1;
        adv(3);                                             // E10
        up_down = 1'b0;
        check_bit("glitch_dir_e10", dut.up_down_db, 1'b0);
        push("glitch_down_a", 4'hA); adv(3); pop_check();   // E13
        push("glitch_down_7", 4'h7); adv(7); pop_check();   // E20
        check_bit("glitch_dir_e20", dut.up_down_db, 1'b0);

        up_down = 1'b1;
        push("deb_pending_2", 4'h2); adv(9); pop_check();   // E29
        check_bit("deb_edge_minus1", dut.up_down_db, 1'b0);
        adv(1);                                             // E30
        check_bit("deb_edge_10", dut.up_down_db, 1'b1);
        push("up_3", 4'h3);          adv(1);  pop_check();  // E31
        push("up_4", 4'h4);          adv(2);  pop_check();  // E33
        push("up_f", 4'hF);          adv(22); pop_check();  // E55
        push("up_wrap_0", 4'h0);     adv(2);  pop_check();  // E57
        push("up_1", 4'h1);          adv(2);  pop_check();  // E59

        data_in = 4'b1001;
        load    = 1'b1;
        push("load_pending_6", 4'h6); adv(10); pop_check(); // E69
        push("load_9", 4'h9);         adv(1);  pop_check(); // E70
        push("load_hold_tick", 4'h9); adv(1);  pop_check(); // E71
        push("load_hold_e75", 4'h9);  adv(4);  pop_check(); // E75

        load = 1'b0;
        push("unload_pending", 4'h9); adv(10); pop_check(); // E85
        push("unload_no_tick", 4'h9); adv(1);  pop_check(); // E86
        push("unload_up_a", 4'hA);    adv(1);  pop_check(); // E87

        #3;
        rst = 1'b0;
        #1;
        push("arst_immediate", 4'h0); pop_check();
        push("arst_held", 4'h0);      adv(1);  pop_check();
        rst = 1'b1;
        push("arst_rel_e2", 4'h0);    adv(2);  pop_check(); // E2
        // Raw up_down is still high, but the debounced value restarted at 0.
        push("arst_down_f", 4'hF);    adv(1);  pop_check(); // E3

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
